// File: rtl/lv_efuse_loader_if.sv
// lv_efuse_loader_if -- control-FSM, eFuse-macro and register-bank signals of
// the LV eFuse loader, bundled into one interface.
//   slave  : the loader side (lv_efuse_loader)
//   master : the environment side (control FSM, eFuse macro, register bank)
// Signals:
//   i_pwr_on, i_efuse_load_req        control FSM -> loader
//   o_efuse_load_done                 loader -> control FSM, 1-cycle pulse
//   o_efuse_rd_en, o_efuse_addr       loader -> macro read strobe/address
//   i_efuse_rdata                     macro -> loader read data
//   o_efuse_wr_vld/_wr_addr/_wr_data  loader -> register-bank write
//   o_efuse_vld, o_efuse_chk_err      status levels
interface lv_efuse_loader_if #(
  parameter int EFUSE_DW = 8,
  parameter int EFUSE_AW = 3
);
  logic                i_pwr_on;
  logic                i_efuse_load_req;
  logic                o_efuse_load_done;
  logic                o_efuse_rd_en;
  logic [EFUSE_AW-1:0] o_efuse_addr;
  logic [EFUSE_DW-1:0] i_efuse_rdata;
  logic                o_efuse_wr_vld;
  logic [EFUSE_AW-1:0] o_efuse_wr_addr;
  logic [EFUSE_DW-1:0] o_efuse_wr_data;
  logic                o_efuse_vld;
  logic                o_efuse_chk_err;

  modport slave (
    input  i_pwr_on, i_efuse_load_req, i_efuse_rdata,
    output o_efuse_load_done, o_efuse_rd_en, o_efuse_addr,
           o_efuse_wr_vld, o_efuse_wr_addr, o_efuse_wr_data,
           o_efuse_vld, o_efuse_chk_err
  );

  modport master (
    output i_pwr_on, i_efuse_load_req, i_efuse_rdata,
    input  o_efuse_load_done, o_efuse_rd_en, o_efuse_addr,
           o_efuse_wr_vld, o_efuse_wr_addr, o_efuse_wr_data,
           o_efuse_vld, o_efuse_chk_err
  );
endinterface

// File: rtl/lv_efuse_loader.sv
// lv_efuse_loader -- LV-domain eFuse load responder.
// On a load request it reads EFUSE_WORDS words from the eFuse macro (each
// read strobe held RD_WAIT cycles), writes every word into the register bank,
// then validates the XOR checksum held in the last word and returns a
// one-cycle done pulse plus validity/error levels.
// Ports:
//   i_clk  system clock
//   i_rst  synchronous active-high reset
//   bus    lv_efuse_loader_if.slave (control, macro, register-bank signals)
// Configuration macro:
//   EFUSE_CHKSUM_EN  defined: XOR checksum compare drives o_efuse_vld /
//                    o_efuse_chk_err. Undefined: no accumulator, vld=1 at
//                    DONE, chk_err tied 0; latency identical.
// All outputs are registers; each is loaded from the next-state decode so it
// is asserted in the same cycle the FSM sits in the corresponding state.
module lv_efuse_loader #(
  parameter int EFUSE_WORDS = 8,
  parameter int EFUSE_DW    = 8,
  parameter int EFUSE_AW    = 3,
  parameter int RD_WAIT     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  lv_efuse_loader_if.slave  bus
);

  localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [EFUSE_AW-1:0] LAST_IDX  = EFUSE_AW'(EFUSE_WORDS - 1);
  localparam logic [WW-1:0]       LAST_WAIT = WW'(RD_WAIT - 1);

  typedef enum logic [2:0] {IDLE, RD, WR, CHK, DONE, REL} state_e;

  state_e              state_q, state_d;
  logic [EFUSE_AW-1:0] idx_q, idx_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [EFUSE_DW-1:0] data_q, data_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_vld_q, wr_vld_d;
  logic                done_q, done_d;
  logic                vld_q, vld_d;
  logic                err_q, err_d;
`ifdef EFUSE_CHKSUM_EN
  logic [EFUSE_DW-1:0] acc_q, acc_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    data_d  = data_q;
    vld_d   = vld_q;
    err_d   = err_q;
`ifdef EFUSE_CHKSUM_EN
    acc_d   = acc_q;
`endif
    // Power loss outside IDLE aborts the load silently: no done pulse and
    // the status levels are cleared.
    if (state_q != IDLE && !bus.i_pwr_on) begin
      state_d = IDLE;
      idx_d   = '0;
      wait_d  = '0;
      vld_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_pwr_on && bus.i_efuse_load_req) begin
            state_d = RD;
            idx_d   = '0;
            wait_d  = '0;
            vld_d   = 1'b0;
            err_d   = 1'b0;
`ifdef EFUSE_CHKSUM_EN
            acc_d   = '0;
`endif
          end
        end
        RD: begin
          // Macro data is valid on the last strobe cycle only.
          if (wait_q == LAST_WAIT) begin
            state_d = WR;
            data_d  = bus.i_efuse_rdata;
            wait_d  = '0;
          end else begin
            wait_d  = WW'(wait_q + 1'b1);
          end
        end
        WR: begin
          if (idx_q == LAST_IDX) begin
            state_d = CHK;   // counter parks on the checksum word
          end else begin
`ifdef EFUSE_CHKSUM_EN
            acc_d   = acc_q ^ data_q;
`endif
            idx_d   = idx_q + 1'b1;
            state_d = RD;
          end
        end
        CHK: begin
          // data_q still holds the checksum word written last.
          state_d = DONE;
`ifdef EFUSE_CHKSUM_EN
          vld_d   = (acc_q == data_q);
          err_d   = (acc_q != data_q);
`else
          vld_d   = 1'b1;
          err_d   = 1'b0;
`endif
        end
        DONE: state_d = REL;
        // A request left high must not start a second load.
        REL: if (!bus.i_efuse_load_req) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    rd_en_d  = (state_d == RD);
    wr_vld_d = (state_d == WR);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wait_q   <= '0;
      data_q   <= '0;
      rd_en_q  <= 1'b0;
      wr_vld_q <= 1'b0;
      done_q   <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef EFUSE_CHKSUM_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      data_q   <= data_d;
      rd_en_q  <= rd_en_d;
      wr_vld_q <= wr_vld_d;
      done_q   <= done_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
`ifdef EFUSE_CHKSUM_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign bus.o_efuse_rd_en     = rd_en_q;
  assign bus.o_efuse_addr      = idx_q;
  assign bus.o_efuse_wr_vld    = wr_vld_q;
  assign bus.o_efuse_wr_addr   = idx_q;
  assign bus.o_efuse_wr_data   = data_q;
  assign bus.o_efuse_load_done = done_q;
  assign bus.o_efuse_vld       = vld_q;
  assign bus.o_efuse_chk_err   = err_q;

endmodule
